operand_buffer: RTL and testbench
=================================

OPERAND_BUFFER -- requirements
Module: operand_buffer

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits.
REQ-002 Parameter DEPTH, default 4, entry count; power of two, at least 2.
REQ-003 Parameter LOAD_BIT, default 7, index of the control_signal bit that pushes from_MBR.
REQ-004 Parameter CLR_BIT, default 8, index of the control_signal bit that flushes the buffer.
REQ-005 clk  in  1  rising-edge clock; the block SHALL use this one clock only.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 control_signal  in  32  CPU control word; only LOAD_BIT and CLR_BIT are used.
REQ-008 from_MBR  in  WIDTH  operand to push.
REQ-009 pop  in  1  ALU has consumed the head operand.
REQ-010 to_ALU  out  WIDTH  head operand, or last popped value when the buffer is empty.
REQ-011 count  out  $clog2(DEPTH+1)  number of valid entries.
REQ-012 empty, full  out  1 each  count==0 and count==DEPTH.
REQ-013 overflow, underflow  out  1 each  sticky error flags.

Function
REQ-014 push = control_signal[LOAD_BIT]; clr = control_signal[CLR_BIT]; all state SHALL update on the rising edge of clk only.
REQ-015 Storage SHALL be a circular FIFO with write and read pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-016 Push when not full: write from_MBR at the write pointer, advance the write pointer, count+1.
REQ-017 Pop when not empty: copy the head to the last-value register, advance the read pointer, count-1.
REQ-018 Push and pop together when not empty and not full: both take effect and count is unchanged.
REQ-019 Push and pop together when full: both take effect, count stays DEPTH, and overflow is not set.
REQ-020 Push when full without pop: drop the data, leave state unchanged, and set overflow.
REQ-021 Pop when empty: ignore it and set underflow; if push is also asserted, the push is still accepted.
REQ-022 clr has priority over push and pop in the same cycle: pointers, count, overflow and underflow go to 0; the last-value register and the storage contents are kept.
REQ-023 to_ALU SHALL be combinational from state: storage[read pointer] when count>0, otherwise the last-value register.
REQ-024 Latency: data pushed into an empty buffer at edge k SHALL appear on to_ALU immediately after edge k.
REQ-025 With pop tied low and DEPTH entries filled, to_ALU SHALL hold the oldest entry indefinitely.
REQ-026 count, empty and full SHALL be consistent with each other in every cycle.

Reset
REQ-027 When rst is asserted, pointers, count, the last-value register, overflow and underflow SHALL go to 0 asynchronously.
REQ-028 Under reset, to_ALU=0, empty=1, full=0 and count=0.
REQ-029 Reset asserted mid-operation SHALL abort any pending push or pop; storage contents need not be cleared.
REQ-030 After rst deasserts, the first edge with push asserted SHALL be accepted normally.

Structure
REQ-031 The control-word width (32) and the bit indices LOAD_BIT_IDX=7 and CLR_BIT_IDX=8 SHALL live in the shared package cpu_pkg; parameter defaults SHALL reference them.
REQ-032 The storage array SHALL be one sub-module, obuf_mem (synchronous write, asynchronous read, no reset); pointer, count and flag logic stays in operand_buffer.

Verification (WIDTH=16, DEPTH=4)
REQ-033 Reset, then push 0x1234 -> after the edge: to_ALU=0x1234, count=1, empty=0.
REQ-034 Push 0xA, 0xB, 0xC, 0xD, then push 0xE -> full=1, overflow=1; four pops return A, B, C, D; after the pops to_ALU=0xD and empty=1.
REQ-035 Push and pop together on a full buffer (A..D), pushing 0xE -> count=4, to_ALU=0xB, overflow=0; later pops return B, C, D, E (pointer wrap).
REQ-036 Pop on an empty buffer in the same cycle as a push of 0x55 -> underflow=1, count=1, to_ALU=0x55.
REQ-037 Two entries held, then clr with push of 0x77 in the same cycle -> count=0, flags=0, to_ALU keeps the last-value register and 0x77 is dropped.
REQ-038 Assert rst asynchronously between edges while count=3 -> count=0 and to_ALU=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU-wide constants: control-word width, the control
//               bit indices used by the operand buffer, and a helper for
//               sizing FIFO pointers.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int CTRL_WIDTH   = 32;
    localparam int LOAD_BIT_IDX = 7;
    localparam int CLR_BIT_IDX  = 8;

    typedef logic [CTRL_WIDTH-1:0] ctrl_word_t;

    // Pointer width for a power-of-two FIFO; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/obuf_mem.sv
`default_nettype none
// ============================================================================
// Module      : obuf_mem
// Description : Operand storage array. Synchronous write, asynchronous read,
//               no reset (contents are don't-care until written).
// Ports       : clk     - write clock
//               i_we    - write enable
//               i_waddr - write address
//               i_wdata - write data
//               i_raddr - read address
//               o_rdata - combinational read data
// Revision    : 1.0 - initial release
// ============================================================================
module obuf_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem_q[i_raddr];

endmodule
`default_nettype wire

// File: rtl/operand_buffer.sv
`default_nettype none
// ============================================================================
// Module      : operand_buffer
// Description : Circular FIFO of ALU operands loaded from the MBR. Holds the
//               last popped value so the ALU sees a stable operand when the
//               buffer runs dry. Sticky overflow/underflow flags, flushable
//               by a control-word clear bit.
// Ports       : clk            - rising-edge clock
//               rst            - asynchronous active-high reset
//               control_signal - CPU control word (LOAD_BIT pushes, CLR_BIT
//                                flushes; other bits ignored)
//               from_MBR       - operand to push
//               pop            - ALU consumed the head operand
//               to_ALU         - head operand, or last popped value if empty
//               count          - number of valid entries
//               empty / full   - count==0 / count==DEPTH
//               overflow       - sticky: push while full without pop
//               underflow      - sticky: pop while empty
// Revision    : 1.0 - initial release
// ============================================================================
module operand_buffer
    import cpu_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 4,
    parameter int LOAD_BIT = LOAD_BIT_IDX,
    parameter int CLR_BIT  = CLR_BIT_IDX
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CTRL_WIDTH-1:0]      control_signal,
    input  logic [WIDTH-1:0]           from_MBR,
    input  logic                       pop,
    output logic [WIDTH-1:0]           to_ALU,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    localparam logic [CW-1:0] c_cnt_full = CW'(DEPTH);
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);
    localparam logic [AW-1:0] c_ptr_one  = AW'(1);

    logic [AW-1:0]    r_wptr_q, w_wptr_d;
    logic [AW-1:0]    r_rptr_q, w_rptr_d;
    logic [CW-1:0]    r_count_q, w_count_d;
    logic [WIDTH-1:0] r_last_q, w_last_d;
    logic             r_overflow_q, w_overflow_d;
    logic             r_underflow_q, w_underflow_d;

    logic             w_push;
    logic             w_clr;
    logic             w_empty;
    logic             w_full;
    logic             w_push_acc;
    logic             w_pop_acc;
    logic             w_we;
    logic [WIDTH-1:0] w_head;
    logic             w_unused_ctrl;

    assign w_push  = control_signal[LOAD_BIT];
    assign w_clr   = control_signal[CLR_BIT];
    assign w_empty = (r_count_q == '0);
    assign w_full  = (r_count_q == c_cnt_full);

    // Only two control bits matter; fold the rest so they are visibly consumed.
    assign w_unused_ctrl = ^control_signal;

    // A pop on a full buffer frees the slot the simultaneous push writes into.
    // When full, wptr==rptr, so the write lands on the entry being popped; the
    // head is read before the edge, so the popped value is not corrupted.
    assign w_pop_acc  = pop && !w_empty;
    assign w_push_acc = w_push && (!w_full || pop);
    assign w_we       = w_push_acc && !w_clr;

    obuf_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wptr_q),
        .i_wdata (from_MBR),
        .i_raddr (r_rptr_q),
        .o_rdata (w_head)
    );

    always_comb begin
        w_wptr_d      = r_wptr_q;
        w_rptr_d      = r_rptr_q;
        w_count_d     = r_count_q;
        w_last_d      = r_last_q;
        w_overflow_d  = r_overflow_q;
        w_underflow_d = r_underflow_q;

        if (w_clr) begin
            // Flush: last-value register and storage contents survive.
            w_wptr_d      = '0;
            w_rptr_d      = '0;
            w_count_d     = '0;
            w_overflow_d  = 1'b0;
            w_underflow_d = 1'b0;
        end else begin
            if (w_push_acc) begin
                w_wptr_d = r_wptr_q + c_ptr_one;
            end
            if (w_pop_acc) begin
                w_rptr_d = r_rptr_q + c_ptr_one;
                w_last_d = w_head;
            end
            if (w_push_acc && !w_pop_acc) begin
                w_count_d = r_count_q + c_cnt_one;
            end else if (!w_push_acc && w_pop_acc) begin
                w_count_d = r_count_q - c_cnt_one;
            end
            if (w_push && w_full && !pop) begin
                w_overflow_d = 1'b1;
            end
            if (pop && w_empty) begin
                w_underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr_q      <= '0;
            r_rptr_q      <= '0;
            r_count_q     <= '0;
            r_last_q      <= '0;
            r_overflow_q  <= 1'b0;
            r_underflow_q <= 1'b0;
        end else begin
            r_wptr_q      <= w_wptr_d;
            r_rptr_q      <= w_rptr_d;
            r_count_q     <= w_count_d;
            r_last_q      <= w_last_d;
            r_overflow_q  <= w_overflow_d;
            r_underflow_q <= w_underflow_d;
        end
    end

    assign to_ALU    = w_empty ? r_last_q : w_head;
    assign count     = r_count_q;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_overflow_q;
    assign underflow = r_underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_buffer
// Description : Self-checking bench for operand_buffer (WIDTH=16, DEPTH=4).
//               Driver issues directed then random cycles against a queue
//               based reference model and pushes the expected post-edge state
//               into a scoreboard; a monitor pops and compares each negedge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_buffer;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [31:0]      control_signal = '0;
    logic [WIDTH-1:0] from_MBR = '0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] to_ALU;
    logic [CW-1:0]    count;
    logic             empty, full, overflow, underflow;

    operand_buffer #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .LOAD_BIT (7),
        .CLR_BIT  (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .control_signal (control_signal),
        .from_MBR       (from_MBR),
        .pop            (pop),
        .to_ALU         (to_ALU),
        .count          (count),
        .empty          (empty),
        .full           (full),
        .overflow       (overflow),
        .underflow      (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] to_alu;
        int               cnt;
        bit               ovf;
        bit               udf;
        bit               pv;
        logic [WIDTH-1:0] pval;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: a plain queue of operands plus the held value.
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] mlast = '0;
    bit               movf  = 1'b0;
    bit               mudf  = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_cycle(input bit p, input bit q, input bit c,
                            input logic [WIDTH-1:0] d, input logic [31:0] noise);
        exp_t        e;
        logic [31:0] cs;
        bit          popped;
        bit          push_ok;
        @(negedge clk);
        #1;
        cs             = noise;
        cs[7]          = p;
        cs[8]          = c;
        control_signal = cs;
        from_MBR       = d;
        pop            = q;

        e.pv   = 1'b0;
        e.pval = '0;
        if (c) begin
            mq.delete();
            movf = 1'b0;
            mudf = 1'b0;
        end else begin
            popped  = q && (mq.size() > 0);
            push_ok = p && ((mq.size() < DEPTH) || popped);
            if (q && mq.size() == 0) mudf = 1'b1;
            if (p && mq.size() == DEPTH && !q) movf = 1'b1;
            if (popped) begin
                e.pv   = 1'b1;
                e.pval = mq[0];
                mlast  = mq.pop_front();
            end
            if (push_ok) mq.push_back(d);
        end
        e.to_alu = (mq.size() > 0) ? mq[0] : mlast;
        e.cnt    = mq.size();
        e.ovf    = movf;
        e.udf    = mudf;

        @(posedge clk);
        exp_q.push_back(e);
        #1;
        control_signal[7] = 1'b0;
        control_signal[8] = 1'b0;
        pop               = 1'b0;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    // Monitor: compares the state the DUT presents after each scored edge.
    logic [WIDTH-1:0] prev_alu = '0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.pv) check("popped_value", 32'(prev_alu), 32'(e.pval));
                check("to_ALU",    32'(to_ALU),    32'(e.to_alu));
                check("count",     32'(count),     32'(e.cnt));
                check("empty",     32'(empty),     32'(e.cnt == 0));
                check("full",      32'(full),      32'(e.cnt == DEPTH));
                check("overflow",  32'(overflow),  32'(e.ovf));
                check("underflow", 32'(underflow), 32'(e.udf));
            end
            prev_alu = to_ALU;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] vals [4];
        vals[0] = 16'h000A; vals[1] = 16'h000B; vals[2] = 16'h000C; vals[3] = 16'h000D;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_to_ALU", 32'(to_ALU), 32'h0);
        check("rst_count",  32'(count),  32'h0);
        check("rst_empty",  32'(empty),  32'h1);
        check("rst_full",   32'(full),   32'h0);
        check("rst_flags",  32'({overflow, underflow}), 32'h0);
        #1 rst = 1'b0;

        // First push lands on to_ALU right after the edge
        do_cycle(1, 0, 0, 16'h1234, 32'h0);
        sample();
        check("first_push_to_ALU", 32'(to_ALU), 32'h1234);
        check("first_push_count",  32'(count),  32'h1);
        check("first_push_empty",  32'(empty),  32'h0);
        do_cycle(0, 0, 1, 16'h0, 32'h0);

        // Fill, overflow, hold oldest, drain
        for (int i = 0; i < 4; i++) do_cycle(1, 0, 0, vals[i], 32'h0);
        do_cycle(1, 0, 0, 16'h000E, 32'h0);
        sample();
        check("ovf_full",     32'(full),     32'h1);
        check("ovf_flag",     32'(overflow), 32'h1);
        repeat (3) @(negedge clk);
        check("hold_oldest",  32'(to_ALU),   32'h000A);
        for (int i = 0; i < 4; i++) do_cycle(0, 1, 0, 16'h0, 32'h0);
        sample();
        check("drain_last",   32'(to_ALU),   32'h000D);
        check("drain_empty",  32'(empty),    32'h1);
        do_cycle(0, 0, 1, 16'h0, 32'h0);

        // Push+pop on full buffer, then drain across the pointer wrap
        for (int i = 0; i < 4; i++) do_cycle(1, 0, 0, vals[i], 32'h0);
        do_cycle(1, 1, 0, 16'h000E, 32'h0);
        sample();
        check("pp_full_count", 32'(count),    32'h4);
        check("pp_full_head",  32'(to_ALU),   32'h000B);
        check("pp_full_ovf",   32'(overflow), 32'h0);
        for (int i = 0; i < 4; i++) do_cycle(0, 1, 0, 16'h0, 32'h0);
        sample();
        check("wrap_last",     32'(to_ALU),   32'h000E);

        // Pop on empty with simultaneous push
        do_cycle(1, 1, 0, 16'h0055, 32'h0);
        sample();
        check("udf_flag",   32'(underflow), 32'h1);
        check("udf_count",  32'(count),     32'h1);
        check("udf_to_ALU", 32'(to_ALU),    32'h0055);
        do_cycle(0, 0, 1, 16'h0, 32'h0);

        // Clear beats push
        do_cycle(1, 0, 0, 16'h0011, 32'h0);
        do_cycle(1, 0, 0, 16'h0022, 32'h0);
        do_cycle(1, 0, 1, 16'h0077, 32'h0);
        sample();
        check("clr_count",  32'(count),  32'h0);
        check("clr_flags",  32'({overflow, underflow}), 32'h0);
        check("clr_to_ALU", 32'(to_ALU), 32'h000E);

        // Asynchronous reset between edges
        do_cycle(1, 0, 0, 16'h0001, 32'h0);
        do_cycle(1, 0, 0, 16'h0002, 32'h0);
        do_cycle(1, 0, 0, 16'h0003, 32'h0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_count",  32'(count),  32'h0);
        check("arst_to_ALU", 32'(to_ALU), 32'h0);
        check("arst_empty",  32'(empty),  32'h1);
        check("arst_full",   32'(full),   32'h0);
        mq.delete();
        mlast = '0;
        movf  = 1'b0;
        mudf  = 1'b0;
        #1 rst = 1'b0;

        // First push after reset accepted
        do_cycle(1, 0, 0, 16'h0099, 32'h0);
        sample();
        check("post_rst_to_ALU", 32'(to_ALU), 32'h0099);
        check("post_rst_count",  32'(count),  32'h1);

        // Random traffic, with the unused control bits toggling
        for (int n = 0; n < 3000; n++) begin
            do_cycle($urandom_range(0, 99) < 55,
                     $urandom_range(0, 99) < 45,
                     $urandom_range(0, 99) < 3,
                     WIDTH'($urandom),
                     $urandom);
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
